// File: rtl/nn_pkg.sv
// Shared constants for the neuron accumulator bank: one-hot layer codes, fan-in sizes, FSM states.
// Layer codes not matching a single one-hot value collapse to LAYER_NONE.
package nn_pkg;

    localparam logic [2:0] LAYER_NONE = 3'b000;
    localparam logic [2:0] LAYER_1    = 3'b001;
    localparam logic [2:0] LAYER_2    = 3'b010;
    localparam logic [2:0] LAYER_3    = 3'b100;

    localparam int FANIN_L1  = 784;
    localparam int FANIN_HID = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_FINISH,
        ST_HOLD
    } state_t;

    function automatic logic [2:0] layer_sanitize(input logic [2:0] layer);
        if (layer == LAYER_1 || layer == LAYER_2 || layer == LAYER_3)
            return layer;
        return LAYER_NONE;
    endfunction

    function automatic logic [9:0] fanin_of(input logic [2:0] layer);
        return (layer == LAYER_1) ? 10'(FANIN_L1) : 10'(FANIN_HID);
    endfunction

endpackage

// File: rtl/neuron_mac.sv
// One neuron lane: multiply-accumulate, then bias, arithmetic shift, optional ReLU and clamp.
// ACC_SAT_EN selects saturating accumulation with a clip flag; otherwise the accumulator wraps.
module neuron_mac
    import nn_pkg::*;
#(
    parameter int IN_W       = 8,
    parameter int WT_W       = 8,
    parameter int ACC_W      = 24,
    parameter int OUT_W      = 8,
    parameter int FRAC_SHIFT = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    en,
    input  logic                    signed_mode,
    input  logic [IN_W-1:0]         act,
    input  logic signed [WT_W-1:0]  weight,
    input  logic signed [WT_W-1:0]  bias,
    output logic [OUT_W-1:0]        result,
    output logic                    clip
);

    localparam int PW = IN_W + WT_W + 1;
    localparam int SW = ACC_W + 1;
    localparam logic signed [SW-1:0] U_MAX = SW'((1 << OUT_W) - 1);
    localparam logic signed [SW-1:0] S_MAX = SW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [SW-1:0] S_MIN = SW'(-(1 << (OUT_W - 1)));

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [PW-1:0]    prod;

    // Activation is unsigned: a zero MSB keeps it positive in the signed product.
    assign prod = PW'($signed({1'b0, act})) * PW'(weight);

`ifdef ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [SW-1:0] sum;
    logic                 ovf;

    assign sum      = $signed({acc[ACC_W-1], acc}) + SW'(prod);
    assign ovf      = sum[ACC_W] ^ sum[ACC_W-1];
    assign acc_next = ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
    assign clip     = en & ovf;
`else
    assign acc_next = acc + ACC_W'(prod);
    assign clip     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

    logic signed [SW-1:0] biased;
    logic signed [SW-1:0] shifted;

    assign biased  = $signed({acc[ACC_W-1], acc}) + SW'(bias);
    assign shifted = biased >>> FRAC_SHIFT;

    always_comb begin
        result = shifted[OUT_W-1:0];
        if (signed_mode) begin
            if (shifted > S_MAX)
                result = {1'b0, {(OUT_W-1){1'b1}}};
            else if (shifted < S_MIN)
                result = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            if (shifted[SW-1])
                result = '0;
            else if (shifted > U_MAX)
                result = '1;
        end
    end

endmodule

// File: rtl/neuron_accumulator_bank.sv
// Layer FSM, layer-change detection and output registers around N_NEURONS neuron_mac lanes.
// Out_Valid pulses one cycle after the first LD_IO of a layer; optional ACC_SAT_EN drives Ovf.
module neuron_accumulator_bank
    import nn_pkg::*;
#(
    parameter int N_NEURONS  = 20,
    parameter int IN_W       = 8,
    parameter int WT_W       = 8,
    parameter int ACC_W      = 24,
    parameter int OUT_W      = 8,
    parameter int FRAC_SHIFT = 7
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic [2:0]                  Layer,
    input  logic [9:0]                  Tick,
    input  logic                        LD_IO,
    input  logic [IN_W-1:0]             Act_In,
    input  logic [N_NEURONS*WT_W-1:0]   Weights,
    input  logic [N_NEURONS*WT_W-1:0]   Biases,
    output logic [N_NEURONS*OUT_W-1:0]  Act_Out,
    output logic                        Out_Valid,
    output logic [2:0]                  Out_Layer,
    output logic                        Busy,
    output logic                        Ovf
);

    state_t                       state;
    logic [2:0]                   layer_v;
    logic [2:0]                   prev_layer;
    logic [2:0]                   cur_layer;
    logic [9:0]                   fanin;
    logic                         change;
    logic                         acc_en;
    logic [N_NEURONS*OUT_W-1:0]   lane_res;
    logic [N_NEURONS-1:0]         lane_clip;

    assign layer_v = layer_sanitize(Layer);
    assign change  = (layer_v != LAYER_NONE) && (layer_v != prev_layer);
    assign acc_en  = (state == ST_ACCUM) && !change && (layer_v != LAYER_NONE)
                   && (Tick >= 10'd1) && (Tick <= fanin);

    for (genvar i = 0; i < N_NEURONS; i++) begin : g_lane
        neuron_mac #(
            .IN_W       (IN_W),
            .WT_W       (WT_W),
            .ACC_W      (ACC_W),
            .OUT_W      (OUT_W),
            .FRAC_SHIFT (FRAC_SHIFT)
        ) u_mac (
            .clk         (Clk),
            .rst_n       (Reset_n),
            .clear       (change),
            .en          (acc_en),
            .signed_mode (cur_layer == LAYER_3),
            .act         (Act_In),
            .weight      (Weights[i*WT_W +: WT_W]),
            .bias        (Biases[i*WT_W +: WT_W]),
            .result      (lane_res[i*OUT_W +: OUT_W]),
            .clip        (lane_clip[i])
        );
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= ST_IDLE;
            prev_layer <= LAYER_NONE;
            cur_layer  <= LAYER_NONE;
            fanin      <= '0;
            Act_Out    <= '0;
            Out_Valid  <= 1'b0;
            Out_Layer  <= LAYER_NONE;
            Busy       <= 1'b0;
            Ovf        <= 1'b0;
        end else begin
            prev_layer <= layer_v;
            Out_Valid  <= 1'b0;
            // A new non-zero layer restarts accumulation from any state, aborting an open layer.
            if (change) begin
                state     <= ST_ACCUM;
                cur_layer <= layer_v;
                fanin     <= fanin_of(layer_v);
                Busy      <= 1'b1;
                Ovf       <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end
                    ST_ACCUM: begin
                        if (layer_v == LAYER_NONE) begin
                            state <= ST_IDLE;
                            Busy  <= 1'b0;
                        end else begin
                            Ovf <= Ovf | (acc_en & (|lane_clip));
                            if (LD_IO) begin
                                state     <= ST_FINISH;
                                Busy      <= 1'b0;
                                Act_Out   <= lane_res;
                                Out_Valid <= 1'b1;
                                Out_Layer <= cur_layer;
                            end
                        end
                    end
                    ST_FINISH: begin
                        state <= (layer_v == LAYER_NONE) ? ST_IDLE : ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (layer_v == LAYER_NONE)
                            state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_neuron_accumulator_bank.sv
// Directed bench for neuron_accumulator_bank: arithmetic reference model, per-cycle compare, literal pins.
module tb_neuron_accumulator_bank;

    localparam int N  = 20;
    localparam int VW = N * 8;
    localparam longint ACC_MAX = (64'sd1 <<< 23) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< 23);

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic [2:0]    Layer;
    logic [9:0]    Tick;
    logic          LD_IO;
    logic [7:0]    Act_In;
    logic [VW-1:0] Weights;
    logic [VW-1:0] Biases;
    logic [VW-1:0] Act_Out;
    logic          Out_Valid;
    logic [2:0]    Out_Layer;
    logic          Busy;
    logic          Ovf;

    always #5 Clk = ~Clk;

    neuron_accumulator_bank dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Layer     (Layer),
        .Tick      (Tick),
        .LD_IO     (LD_IO),
        .Act_In    (Act_In),
        .Weights   (Weights),
        .Biases    (Biases),
        .Act_Out   (Act_Out),
        .Out_Valid (Out_Valid),
        .Out_Layer (Out_Layer),
        .Busy      (Busy),
        .Ovf       (Ovf)
    );

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    bit chk_en   = 1'b0;

    longint        macc [N];
    logic [VW-1:0] exp_act   = '0;
    logic          exp_valid = 1'b0;
    logic [2:0]    exp_layer = 3'b000;
    logic          exp_busy  = 1'b0;
    logic          exp_ovf   = 1'b0;

    task automatic chk(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("act_out",   Act_Out,   exp_act);
            chk("out_valid", VW'(Out_Valid), VW'(exp_valid));
            chk("out_layer", VW'(Out_Layer), VW'(exp_layer));
            chk("busy",      VW'(Busy),      VW'(exp_busy));
            chk("ovf",       VW'(Ovf),       VW'(exp_ovf));
        end
    end

    always @(negedge Clk) if (Out_Valid === 1'b1) pulses++;

    // Stimulus patterns: 0 all ones, 1 negative weights, 2 saturating, 3 lane-varying mix.
    function automatic int act_f(int mode, int t);
        case (mode)
            0: return 1;
            1: return 128;
            2: return 255;
            default: return (7 * t) % 256;
        endcase
    endfunction

    function automatic int wt_f(int mode, int lane, int t);
        case (mode)
            0: return 1;
            1: return -1;
            2: return 127;
            default: return (lane - 10) + (t % 3);
        endcase
    endfunction

    function automatic int bias_f(int mode, int lane);
        case (mode)
            2: return 127;
            3: return lane * 5 - 50;
            default: return 0;
        endcase
    endfunction

    task automatic cyc(input logic [2:0] lay, input int t, input bit ld, input int mode);
        Layer  = lay;
        Tick   = 10'(t);
        LD_IO  = ld;
        Act_In = 8'(act_f(mode, t));
        for (int l = 0; l < N; l++) begin
            Weights[l*8 +: 8] = 8'(wt_f(mode, l, t));
            Biases[l*8 +: 8]  = 8'(bias_f(mode, l));
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic model_add(input int mode, input int t);
        longint s;
        logic signed [23:0] tr;
        for (int l = 0; l < N; l++) begin
            s = macc[l] + longint'(act_f(mode, t)) * longint'(wt_f(mode, l, t));
`ifdef ACC_SAT_EN
            if (s > ACC_MAX) begin
                s = ACC_MAX;
                exp_ovf = 1'b1;
            end else if (s < ACC_MIN) begin
                s = ACC_MIN;
                exp_ovf = 1'b1;
            end
`else
            tr = s[23:0];
            s  = longint'(tr);
`endif
            macc[l] = s;
        end
    endtask

    task automatic model_finish(input logic [2:0] lay, input int mode);
        longint v;
        for (int l = 0; l < N; l++) begin
            v = (macc[l] + longint'(bias_f(mode, l))) >>> 7;
            if (lay == 3'b100) begin
                if (v > 127)  v = 127;
                if (v < -128) v = -128;
            end else begin
                if (v < 0)   v = 0;
                if (v > 255) v = 255;
            end
            exp_act[l*8 +: 8] = 8'(v);
        end
    endtask

    task automatic run_layer(input logic [2:0] lay, input int mode, input int fanin,
                             input int start_tick, input int n_ld, input int abort_at);
        cyc(lay, start_tick, 1'b0, mode);
        for (int l = 0; l < N; l++) macc[l] = 0;
        exp_busy  = 1'b1;
        exp_ovf   = 1'b0;
        exp_valid = 1'b0;
        for (int t = 1; t <= fanin; t++) begin
            if (t == abort_at) return;
            cyc(lay, t, 1'b0, mode);
            model_add(mode, t);
        end
        for (int k = 0; k < n_ld; k++) begin
            cyc(lay, fanin + 1 + k, 1'b1, mode);
            if (k == 0) begin
                exp_valid = 1'b1;
                exp_busy  = 1'b0;
                exp_layer = lay;
                model_finish(lay, mode);
            end else begin
                exp_valid = 1'b0;
            end
        end
        cyc(lay, fanin + n_ld + 1, 1'b0, mode);
        exp_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(3'b000, 0, 1'b0, 0);
            exp_busy  = 1'b0;
            exp_valid = 1'b0;
        end
    endtask

    int p0;

    initial begin
        Reset_n = 1'b0;
        cyc(3'b000, 0, 1'b0, 0);
        chk_en = 1'b1;
        cyc(3'b000, 0, 1'b0, 0);
        Reset_n = 1'b1;
        idle(2);

        // L1 all ones: every lane 784 >>> 7 = 6.
        p0 = pulses;
        run_layer(3'b001, 0, 784, 0, 1, 0);
        chk("l1_lane0",  VW'(Act_Out[7:0]),     VW'(8'd6));
        chk("l1_lane19", VW'(Act_Out[159:152]), VW'(8'd6));
        chk("l1_layer",  VW'(Out_Layer),        VW'(3'b001));
        chk("l1_pulses", VW'(pulses - p0),      VW'(1));

        // Negative sums: ReLU zeroes L2, L3 keeps -20.
        run_layer(3'b010, 1, 20, 0, 1, 0);
        chk("l2_relu", Act_Out, {VW{1'b0}});
        run_layer(3'b100, 1, 20, 0, 1, 0);
        chk("l3_lane0", VW'(Act_Out[7:0]),   VW'(8'hEC));
        chk("l3_lane7", VW'(Act_Out[63:56]), VW'(8'hEC));

        // Saturating L1.
        idle(2);
        run_layer(3'b001, 2, 784, 0, 1, 0);
`ifdef ACC_SAT_EN
        chk("sat_lane0", VW'(Act_Out[7:0]), VW'(8'd255));
        chk("sat_ovf",   VW'(Ovf),          VW'(1'b1));
`else
        chk("sat_lane0", VW'(Act_Out[7:0]), VW'(8'd0));
        chk("sat_ovf",   VW'(Ovf),          VW'(1'b0));
`endif

        // Abort L1 at tick 300 by switching to L2.
        idle(2);
        p0 = pulses;
        run_layer(3'b001, 0, 784, 0, 1, 300);
        chk("abort_no_pulse", VW'(pulses - p0), VW'(0));
        run_layer(3'b010, 3, 20, 300, 1, 0);
        chk("abort_pulses", VW'(pulses - p0),        VW'(1));
        chk("abort_lane10", VW'(Act_Out[87:80]),     VW'(8'd12));
        chk("abort_lane19", VW'(Act_Out[159:152]),   VW'(8'd115));
        chk("abort_lane0",  VW'(Act_Out[7:0]),       VW'(8'd0));

        // L3 with LD_IO held three cycles: one pulse, output stable after.
        p0 = pulses;
        run_layer(3'b100, 3, 20, 0, 3, 0);
        chk("rep_pulses", VW'(pulses - p0),   VW'(1));
        chk("rep_lane0",  VW'(Act_Out[7:0]),  VW'(8'h99));
        chk("rep_lane10", VW'(Act_Out[87:80]), VW'(8'd12));

        // Reset in the middle of an L1 layer.
        idle(2);
        p0 = pulses;
        run_layer(3'b001, 0, 784, 0, 1, 400);
        Reset_n = 1'b0;
        cyc(3'b001, 400, 1'b0, 0);
        exp_act   = '0;
        exp_valid = 1'b0;
        exp_layer = 3'b000;
        exp_busy  = 1'b0;
        exp_ovf   = 1'b0;
        Reset_n = 1'b1;
        idle(3);
        chk("rst_no_pulse", VW'(pulses - p0), VW'(0));
        run_layer(3'b010, 3, 20, 0, 1, 0);
        chk("rst_pulses", VW'(pulses - p0), VW'(1));
        idle(2);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
